// File: rtl/binning_nxn.sv
// K x K pixel binning stage: folds a raster pixel stream into one combined pixel per block.
// Combine mode (threshold-count, mean, max) and threshold are latched at each frame start.
module binning_nxn #(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int DATA_WIDTH  = 1,
    parameter int KERNEL_SIZE = 4,
    localparam int LOG_K  = $clog2(KERNEL_SIZE),
    localparam int HWIDTH = $clog2(HRES),
    localparam int VWIDTH = $clog2(VRES),
    localparam int ACC_W  = DATA_WIDTH + 2 * LOG_K
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [HWIDTH-1:0]       hcount_in,
    input  logic [VWIDTH-1:0]       vcount_in,
    input  logic [DATA_WIDTH-1:0]   pixel_data_in,
    input  logic                    data_valid_in,
    input  logic [1:0]              mode_in,
    input  logic [ACC_W-1:0]        threshold_in,
    output logic [DATA_WIDTH-1:0]   pixel_data_out,
    output logic [HWIDTH-LOG_K-1:0] hcount_out,
    output logic [VWIDTH-LOG_K-1:0] vcount_out,
    output logic                    data_valid_out
);
    localparam int COLS = HRES / KERNEL_SIZE;
    localparam int ROWS = VRES / KERNEL_SIZE;
    localparam int CW   = HWIDTH - LOG_K;
    localparam int RW   = VWIDTH - LOG_K;
    localparam int AW   = $clog2(COLS);
    localparam logic [HWIDTH:0] HLIM = (HWIDTH + 1)'(COLS * KERNEL_SIZE);
    localparam logic [VWIDTH:0] VLIM = (VWIDTH + 1)'(ROWS * KERNEL_SIZE);
    localparam logic [1:0] MODE_MEAN = 2'd1;
    localparam logic [1:0] MODE_MAX  = 2'd2;

    typedef logic [ACC_W-1:0] acc_t;

    function automatic acc_t max_acc(input acc_t a, input acc_t b);
        return (a > b) ? a : b;
    endfunction

    logic            frame_seen_r;
    logic [1:0]      mode_r;
    acc_t            thr_r;
    acc_t            acc_r;
    logic            start_s, active_s, close_s, first_row_s, emit_row_s;
    acc_t            pix_ext_s, h_s;
    logic [CW-1:0]   col_s;
    logic [RW-1:0]   row_s;
    logic            s1_valid_r, s1_first_r, s1_emit_r;
    acc_t            s1_h_r, rd_r;
    logic [CW-1:0]   s1_col_r;
    logic [RW-1:0]   s1_row_r;
    acc_t            v_s, mean_s;
    logic [DATA_WIDTH-1:0] binned_s;
    logic            s2_valid_r;
    logic [DATA_WIDTH-1:0] s2_pix_r;
    logic [CW-1:0]   s2_col_r;
    logic [RW-1:0]   s2_row_r;
    acc_t            col_mem [COLS];

    // Stage E: frame gating, horizontal group accumulation and group-close detection.
    always_comb begin
        start_s     = data_valid_in && (hcount_in == {HWIDTH{1'b0}}) && (vcount_in == {VWIDTH{1'b0}});
        active_s    = data_valid_in && (frame_seen_r || start_s);
        col_s       = hcount_in[HWIDTH-1:LOG_K];
        row_s       = vcount_in[VWIDTH-1:LOG_K];
        pix_ext_s   = acc_t'(pixel_data_in);
        if (hcount_in[LOG_K-1:0] == {LOG_K{1'b0}}) begin
            h_s = pix_ext_s;
        end else if (mode_r == MODE_MAX) begin
            h_s = max_acc(acc_r, pix_ext_s);
        end else begin
            h_s = acc_r + pix_ext_s;
        end
        // Partial groups past the last full column never close.
        close_s     = active_s && (hcount_in[LOG_K-1:0] == {LOG_K{1'b1}})
                      && ({1'b0, hcount_in} < HLIM);
        first_row_s = (vcount_in[LOG_K-1:0] == {LOG_K{1'b0}});
        emit_row_s  = (vcount_in[LOG_K-1:0] == {LOG_K{1'b1}}) && ({1'b0, vcount_in} < VLIM);
    end

    // Stage E+1: merge the closed group with the column entry, then apply the combine mode.
    always_comb begin
        mean_s = {ACC_W{1'b0}};
        if (s1_first_r) begin
            v_s = s1_h_r;
        end else if (mode_r == MODE_MAX) begin
            v_s = max_acc(rd_r, s1_h_r);
        end else begin
            v_s = rd_r + s1_h_r;
        end
        case (mode_r)
            MODE_MEAN: begin
                mean_s   = v_s >> (2 * LOG_K);
                binned_s = mean_s[DATA_WIDTH-1:0];
            end
            MODE_MAX: binned_s = v_s[DATA_WIDTH-1:0];
            default:  binned_s = (v_s > thr_r) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
        endcase
    end

    // Control state, pipeline registers and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frame_seen_r   <= 1'b0;
            mode_r         <= 2'd0;
            thr_r          <= {ACC_W{1'b0}};
            acc_r          <= {ACC_W{1'b0}};
            s1_valid_r     <= 1'b0;
            s1_first_r     <= 1'b0;
            s1_emit_r      <= 1'b0;
            s1_h_r         <= {ACC_W{1'b0}};
            s1_col_r       <= {CW{1'b0}};
            s1_row_r       <= {RW{1'b0}};
            s2_valid_r     <= 1'b0;
            s2_pix_r       <= {DATA_WIDTH{1'b0}};
            s2_col_r       <= {CW{1'b0}};
            s2_row_r       <= {RW{1'b0}};
            pixel_data_out <= {DATA_WIDTH{1'b0}};
            hcount_out     <= {CW{1'b0}};
            vcount_out     <= {RW{1'b0}};
            data_valid_out <= 1'b0;
        end else begin
            if (start_s) begin
                frame_seen_r <= 1'b1;
                mode_r       <= mode_in;
                thr_r        <= threshold_in;
            end
            if (active_s) begin
                acc_r <= h_s;
            end
            s1_valid_r <= close_s;
            if (close_s) begin
                s1_h_r     <= h_s;
                s1_col_r   <= col_s;
                s1_row_r   <= row_s;
                s1_first_r <= first_row_s;
                s1_emit_r  <= emit_row_s;
            end
            s2_valid_r <= s1_valid_r && s1_emit_r;
            if (s1_valid_r) begin
                s2_pix_r <= binned_s;
                s2_col_r <= s1_col_r;
                s2_row_r <= s1_row_r;
            end
            data_valid_out <= s2_valid_r;
            if (s2_valid_r) begin
                pixel_data_out <= s2_pix_r;
                hcount_out     <= s2_col_r;
                vcount_out     <= s2_row_r;
            end
        end
    end

    // Column buffer: registered read at group close, write-back of the merged value one cycle later.
    always_ff @(posedge clk_in) begin
        if (close_s) begin
            rd_r <= col_mem[col_s[AW-1:0]];
        end
        if (s1_valid_r && !rst_in) begin
            col_mem[s1_col_r[AW-1:0]] <= v_s;
        end
    end
endmodule

// File: tb/tb_binning_nxn.sv
// Self-checking bench for binning_nxn: directed frames plus random frames compared
// against a block-level reference computed straight from the frame contents.
module tb_binning_nxn;
    localparam int HRES = 18;
    localparam int VRES = 10;
    localparam int DW   = 8;
    localparam int K    = 4;
    localparam int COLS = HRES / K;
    localparam int ROWS = VRES / K;

    typedef struct {
        int pix;
        int hc;
        int vc;
        int cyc;
    } strobe_t;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [4:0]  hcount_in;
    logic [3:0]  vcount_in;
    logic [7:0]  pixel_data_in;
    logic        data_valid_in;
    logic [1:0]  mode_in;
    logic [11:0] threshold_in;
    logic [7:0]  pixel_data_out;
    logic [2:0]  hcount_out;
    logic [1:0]  vcount_out;
    logic        data_valid_out;

    int      cyc = 0;
    int      n_assert = 0;
    int      n_fail = 0;
    int      frame [VRES][HRES];
    strobe_t obs [$];
    strobe_t exp_q [$];

    binning_nxn #(.HRES(HRES), .VRES(VRES), .DATA_WIDTH(DW), .KERNEL_SIZE(K)) dut (
        .clk_in(clk), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .pixel_data_in(pixel_data_in), .data_valid_in(data_valid_in), .mode_in(mode_in),
        .threshold_in(threshold_in), .pixel_data_out(pixel_data_out), .hcount_out(hcount_out),
        .vcount_out(vcount_out), .data_valid_out(data_valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid_out) begin
            obs.push_back('{int'(pixel_data_out), int'(hcount_out), int'(vcount_out), cyc});
        end
    end

    // Reference block value: 0 THRESH (and 3), 1 MEAN, 2 MAX.
    function automatic int model(input int bc, input int br, input int md, input int thr);
        int s = 0;
        int m = 0;
        for (int y = 0; y < K; y++) begin
            for (int x = 0; x < K; x++) begin
                s += frame[br*K+y][bc*K+x];
                if (frame[br*K+y][bc*K+x] > m) m = frame[br*K+y][bc*K+x];
            end
        end
        if (md == 1) return s / (K * K);
        if (md == 2) return m;
        return (s > thr) ? 255 : 0;
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, int'(data_valid_out), 0);
        check({tag, "_pix"}, int'(pixel_data_out), 0);
        check({tag, "_hc"}, int'(hcount_out), 0);
        check({tag, "_vc"}, int'(vcount_out), 0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        data_valid_in = 1'b0;
        hcount_in     = 5'($urandom);
        vcount_in     = 4'($urandom);
        pixel_data_in = 8'($urandom);
    endtask

    task automatic fill_rand(input int maxv);
        for (int v = 0; v < VRES; v++)
            for (int h = 0; h < HRES; h++)
                frame[v][h] = $urandom_range(0, maxv);
    endtask

    task automatic fill_const(input int val);
        for (int v = 0; v < VRES; v++)
            for (int h = 0; h < HRES; h++)
                frame[v][h] = val;
    endtask

    task automatic compare_frame(input string tag);
        int n;
        repeat (6) idle_cycle();
        check({tag, "_count"}, obs.size(), exp_q.size());
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_pix"}, obs[i].pix, exp_q[i].pix);
            check({tag, "_hc"}, obs[i].hc, exp_q[i].hc);
            check({tag, "_vc"}, obs[i].vc, exp_q[i].vc);
            check({tag, "_time"}, obs[i].cyc, exp_q[i].cyc);
        end
        obs.delete();
        exp_q.delete();
    endtask

    // gap: 0 none, 1 toggle plus a 37-cycle hole, 2 random; abort reset after pixel (ah,av).
    task automatic run_frame(input string tag, input int md, input int thr, input int gap,
                             input int ah, input int av, input bit chg);
        bit aborted = 1'b0;
        obs.delete();
        mode_in      = 2'(md);
        threshold_in = 12'(thr);
        for (int v = 0; v < VRES; v++) begin
            for (int h = 0; h < HRES; h++) begin
                int  idle;
                bit  last;
                idle = (gap == 1) ? 1 : ((gap == 2) ? $urandom_range(0, 2) : 0);
                if (gap == 1 && h == 6 && v == 1) idle = 37;
                for (int k = 0; k < idle; k++) idle_cycle();
                @(negedge clk);
                if (chg && h == 5 && v == 2) begin
                    mode_in      = 2'd2;
                    threshold_in = 12'($urandom);
                end
                data_valid_in = 1'b1;
                hcount_in     = 5'(h);
                vcount_in     = 4'(v);
                pixel_data_in = 8'(frame[v][h]);
                last = (h == ah && v == av);
                if (!aborted && !last && h % K == K - 1 && v % K == K - 1 && h / K < COLS && v / K < ROWS)
                    exp_q.push_back('{model(h / K, v / K, md, thr), h / K, v / K, cyc + 3});
                if (last) begin
                    @(negedge clk);
                    data_valid_in = 1'b0;
                    rst_in        = 1'b1;
                    @(negedge clk);
                    rst_in = 1'b0;
                    check_zero({tag, "_rst"});
                    aborted = 1'b1;
                end
            end
        end
        compare_frame(tag);
    endtask

    initial begin
        rst_in        = 1'b1;
        data_valid_in = 1'b0;
        hcount_in     = 5'd0;
        vcount_in     = 4'd0;
        pixel_data_in = 8'd0;
        mode_in       = 2'd0;
        threshold_in  = 12'd0;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        check_zero("reset");

        // No frame start yet: a full closing row must stay silent.
        for (int h = 0; h < HRES; h++) begin
            @(negedge clk);
            data_valid_in = 1'b1;
            hcount_in     = 5'(h);
            vcount_in     = 4'd3;
            pixel_data_in = 8'd255;
        end
        compare_frame("preframe");

        fill_const(1);
        run_frame("thresh_ones", 0, 8, 0, -1, -1, 1'b0);

        fill_const(0);
        for (int i = 0; i < 8; i++) frame[i / 4][4 + i % 4] = 1;
        for (int i = 0; i < 9; i++) frame[4 + i / 4][8 + i % 4] = 1;
        run_frame("thresh_edge", 0, 8, 0, -1, -1, 1'b0);

        for (int v = 0; v < VRES; v++)
            for (int h = 0; h < HRES; h++)
                frame[v][h] = (v % 4) * 4 + h % 4;
        run_frame("ramp_mean", 1, 0, 0, -1, -1, 1'b0);
        run_frame("ramp_max", 2, 0, 0, -1, -1, 1'b0);

        fill_const(255);
        run_frame("full_mean", 1, 0, 0, -1, -1, 1'b0);

        fill_const(1);
        run_frame("gaps", 0, 8, 1, -1, -1, 1'b0);

        fill_rand(1);
        run_frame("mode_switch", 0, 8, 0, -1, -1, 1'b1);
        fill_rand(255);
        run_frame("next_max", 2, 0, 2, -1, -1, 1'b0);

        fill_rand(255);
        run_frame("abort_9_5", 1, 0, 2, 9, 5, 1'b0);
        fill_rand(255);
        run_frame("after_abort", 0, $urandom_range(0, 4080), 2, -1, -1, 1'b0);

        fill_rand(255);
        run_frame("abort_11_7", 2, 0, 0, 11, 7, 1'b0);
        fill_rand(255);
        run_frame("rand_mean", 1, 0, 2, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
